efuse_wb_shadow_loader: RTL and testbench

- Wishbone classic master (initiator) that reads the eFuse Wishbone memory after reset, or on request.
- Copies NUM_BYTES fuse bytes into a flat shadow register that user logic reads with no bus access.
- Sits between the user-area Wishbone fabric (slave port of the eFuse block) and configuration consumers.
- Generates timeout error and optional CRC check status.

---
 rtl/efuse_wb_shadow_loader.sv | 157 +++++++++++++++
 tb/tb_efuse_wb_shadow_loader.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_wb_shadow_loader.sv
// Wishbone classic master that copies NUM_BYTES eFuse bytes into a flat shadow register.
// Optional macro EFUSE_LOADER_CRC_EN adds crc_ok_o (CRC-8/0x07 over bytes 0..NUM_BYTES-2).
module efuse_wb_shadow_loader #(
  parameter int          NUM_BYTES      = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  input  logic [31:0]            wbm_dat_i,
  input  logic                   wbm_ack_i,
  output logic [NUM_BYTES*8-1:0] shadow_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
`ifdef EFUSE_LOADER_CRC_EN
  ,
  output logic                   crc_ok_o
`endif
);

  localparam logic [5:0]  LAST_IDX = 6'(NUM_BYTES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic                   auto_pend;
  logic [5:0]             idx;
  logic [15:0]            tcnt;
  logic [NUM_BYTES*8-1:0] shadow;
  logic                   err;
  logic                   load_go;
  logic                   ack_req;
  logic                   timeout_hit;

  // Only the low byte of each fuse word carries data.
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i[31:8];

  assign ack_req     = (state == S_REQ) && wbm_ack_i;
  assign timeout_hit = (state == S_REQ) && !wbm_ack_i && (tcnt == TO_LAST);
  assign load_go     = ((state == S_IDLE) && (start_i || auto_pend)) ||
                       ((state == S_DONE) && start_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (load_go) state_nxt = S_REQ;
      S_REQ: begin
        if (ack_req)          state_nxt = (idx == LAST_IDX) ? S_DONE : S_GAP;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_GAP:   state_nxt = S_REQ;
      S_DONE:  if (load_go) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = (state == S_REQ);
    wbm_stb_o = (state == S_REQ);
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'b0001;
    wbm_adr_o = BASE_ADDR + {24'd0, idx, 2'b00};
    busy_o    = (state == S_REQ) || (state == S_GAP);
    done_o    = (state == S_DONE);
  end

  assign shadow_o = shadow;
  assign err_o    = err;

  // auto_pend is high only during the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_pend <= AUTO_START;
      idx       <= '0;
      tcnt      <= '0;
      shadow    <= '0;
      err       <= 1'b0;
    end else begin
      auto_pend <= 1'b0;
      if (load_go) begin
        idx    <= '0;
        tcnt   <= '0;
        shadow <= '0;
        err    <= 1'b0;
      end else begin
        if (ack_req) begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx == 6'(i)) shadow[8*i +: 8] <= wbm_dat_i[7:0];
          end
          tcnt <= '0;
        end else if (timeout_hit) begin
          err  <= 1'b1;
          tcnt <= '0;
        end else if (state == S_REQ) begin
          tcnt <= tcnt + 16'd1;
        end
        if (state == S_GAP) begin
          idx  <= idx + 6'd1;
          tcnt <= '0;
        end
      end
    end
  end

`ifdef EFUSE_LOADER_CRC_EN
  logic [7:0] crc;
  logic       crc_ok;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // The last fuse byte is the stored CRC of the preceding bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc    <= 8'h00;
      crc_ok <= 1'b0;
    end else if (load_go) begin
      crc    <= 8'h00;
      crc_ok <= 1'b0;
    end else if (ack_req) begin
      if (idx != LAST_IDX) crc    <= crc8_step(crc, wbm_dat_i[7:0]);
      else                 crc_ok <= (crc == wbm_dat_i[7:0]);
    end
  end

  assign crc_ok_o = crc_ok;
`endif

endmodule

// File: tb/tb_efuse_wb_shadow_loader.sv
// Self-checking bench for efuse_wb_shadow_loader: randomized fuse contents, wait states and stalls
// on a behavioural Wishbone slave, compared against a transaction-level expectation model.
module tb_efuse_wb_shadow_loader;

  localparam int          N      = 4;
  localparam int          TO     = 10;
  localparam int          BUDGET = 300;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]      wbm_sel_o;
  logic [31:0]     wbm_adr_o;
  logic [31:0]     wbm_dat_i;
  logic            wbm_ack_i;
  logic [N*8-1:0]  shadow_o;
  logic            busy_o, done_o, err_o;
`ifdef EFUSE_LOADER_CRC_EN
  logic            crc_ok_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  efuse_wb_shadow_loader #(
    .NUM_BYTES     (N),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TO),
    .AUTO_START    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .shadow_o (shadow_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
`ifdef EFUSE_LOADER_CRC_EN
    ,
    .crc_ok_o (crc_ok_o)
`endif
  );

  // Behavioural fuse slave: optional wait states, one never-acked byte, spurious acks off-strobe.
  logic [7:0]  fuse [N];
  int          wait_states = 0;
  bit          stall_en = 1'b0;
  int          stall_byte = 0;
  bit          spur_en = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] junk = 32'h0;
  logic [31:0] offs;
  int          sidx;

  always_comb begin
    offs      = wbm_adr_o - BASE;
    sidx      = int'(offs[7:2]);
    wbm_ack_i = 1'b0;
    wbm_dat_i = junk;
    if (wbm_stb_o) begin
      if (!(stall_en && sidx == stall_byte) && wait_cnt >= wait_states && sidx < N) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = {junk[31:8], fuse[sidx]};
      end
    end else if (spur_en) begin
      wbm_ack_i = 1'b1;
    end
  end

  always @(posedge clk) begin
    junk <= $urandom;
    if (wbm_stb_o && !wbm_ack_i) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  // Bus monitor: acked addresses, strobe run lengths, aborted run length, protocol violations.
  logic [31:0] adr_q [$];
  int          run_q [$];
  int          run = 0;
  int          abort_run = 0;
  logic [31:0] run_adr = 32'h0;
  int          bus_viol = 0;
  int          glitch = 0;

  always @(negedge clk) begin
    if (wbm_we_o !== 1'b0 || wbm_sel_o !== 4'b0001 || wbm_cyc_o !== wbm_stb_o) bus_viol++;
    if (wbm_stb_o) begin
      if (run > 0 && wbm_adr_o !== run_adr) glitch++;
      run_adr = wbm_adr_o;
      run++;
      if (wbm_ack_i) begin
        adr_q.push_back(wbm_adr_o);
        run_q.push_back(run);
        run = 0;
      end
    end else begin
      if (run > 0) abort_run = run;
      run = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    adr_q.delete();
    run_q.delete();
    abort_run = 0;
  endtask

  task automatic pulse_start();
    clear_mon();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Cycles from the first strobe sample to the first done sample (first stb cycle is cycle 0).
  task automatic wait_load(output int span, output bit ok);
    int n;
    n = 0;
    while (!wbm_stb_o && n < BUDGET) begin
      tick();
      n++;
    end
    span = 0;
    while (!done_o && span < BUDGET) begin
      tick();
      span++;
    end
    ok = done_o;
  endtask

  function automatic logic [7:0] ref_crc(input int nbytes);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ fuse[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // Expected shadow image: bytes before a stalled byte arrive, the rest stay zero.
  function automatic logic [N*8-1:0] ref_shadow(input bit st, input int sb);
    logic [N*8-1:0] s;
    int             nb;
    s  = '0;
    nb = st ? sb : N;
    for (int i = 0; i < nb; i++) s[8*i +: 8] = fuse[i];
    return s;
  endfunction

  task automatic randomize_fuse();
    for (int i = 0; i < N; i++) fuse[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    repeat (3) tick();
    tests++;
    if ({wbm_cyc_o, wbm_stb_o, busy_o, done_o, err_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: cyc/stb/busy/done/err=%b want 00000",
               {wbm_cyc_o, wbm_stb_o, busy_o, done_o, err_o});
    end
    tests++;
    if (wbm_adr_o !== BASE) begin
      fails++;
      $display("FAIL reset_adr: got %h want %h", wbm_adr_o, BASE);
    end
    tests++;
    if (shadow_o !== '0) begin
      fails++;
      $display("FAIL reset_shadow: got %h want 0", shadow_o);
    end
`ifdef EFUSE_LOADER_CRC_EN
    tests++;
    if (crc_ok_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_crc_ok: got %b want 0", crc_ok_o);
    end
`endif
  endtask

  task automatic test_auto_start();
    int span;
    bit ok;
    fuse[0] = 8'hA1; fuse[1] = 8'hB2; fuse[2] = 8'hC3; fuse[3] = 8'hD4;
    wait_states = 0; stall_en = 1'b0; spur_en = 1'b0;
    clear_mon();
    rst_n = 1'b1;
    wait_load(span, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL auto_done: done never rose within %0d cycles", BUDGET);
    end
    tests++;
    if (span !== 2*N - 1) begin
      fails++;
      $display("FAIL auto_latency: got %0d want %0d", span, 2*N - 1);
    end
    tests++;
    if (shadow_o !== 32'hD4C3B2A1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL auto_result: shadow=%h err=%b busy=%b want D4C3B2A1 0 0", shadow_o, err_o, busy_o);
    end
    tests++;
    if (adr_q.size() != N) begin
      fails++;
      $display("FAIL auto_xfers: got %0d want %0d", adr_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (adr_q[i] !== BASE + 32'(4*i)) begin
          fails++;
          $display("FAIL auto_adr%0d: got %h want %h", i, adr_q[i], BASE + 32'(4*i));
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int span;
    bit ok;
    logic [N*8-1:0] exp_sh;
    randomize_fuse();
    wait_states = 3;
    exp_sh = ref_shadow(1'b0, 0);
    pulse_start();
    wait_load(span, ok);
    tests++;
    if (!ok || span !== N*(3 + 2) - 1) begin
      fails++;
      $display("FAIL wait_latency: done=%b span=%0d want 1 %0d", ok, span, N*5 - 1);
    end
    tests++;
    if (shadow_o !== exp_sh) begin
      fails++;
      $display("FAIL wait_shadow: got %h want %h", shadow_o, exp_sh);
    end
    tests++;
    if (run_q.size() != N) begin
      fails++;
      $display("FAIL wait_xfers: got %0d want %0d", run_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (run_q[i] !== 4) begin
          fails++;
          $display("FAIL wait_stb_len%0d: got %0d want 4", i, run_q[i]);
        end
      end
    end
    wait_states = 0;
  endtask

  task automatic test_timeout();
    int span;
    bit ok;
    logic [N*8-1:0] exp_sh;
    randomize_fuse();
    stall_en = 1'b1; stall_byte = 2;
    exp_sh = ref_shadow(1'b1, 2);
    pulse_start();
    wait_load(span, ok);
    tests++;
    if (!ok || span !== 2*2 + TO) begin
      fails++;
      $display("FAIL to_latency: done=%b span=%0d want 1 %0d", ok, span, 2*2 + TO);
    end
    tests++;
    if (abort_run !== TO) begin
      fails++;
      $display("FAIL to_stb_len: got %0d want %0d", abort_run, TO);
    end
    tests++;
    if (shadow_o !== exp_sh) begin
      fails++;
      $display("FAIL to_shadow: got %h want %h", shadow_o, exp_sh);
    end
    repeat (3) tick();
    tests++;
    if (err_o !== 1'b1 || done_o !== 1'b1 || wbm_stb_o !== 1'b0) begin
      fails++;
      $display("FAIL to_sticky: err=%b done=%b stb=%b want 1 1 0", err_o, done_o, wbm_stb_o);
    end
`ifdef EFUSE_LOADER_CRC_EN
    tests++;
    if (crc_ok_o !== 1'b0) begin
      fails++;
      $display("FAIL to_crc_ok: got %b want 0", crc_ok_o);
    end
`endif
    stall_en = 1'b0;
  endtask

  task automatic test_restart();
    int span;
    logic [N*8-1:0] exp_sh;
    randomize_fuse();
    exp_sh = ref_shadow(1'b0, 0);
    pulse_start();
    tests++;
    if (shadow_o !== '0 || err_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: shadow=%h err=%b done=%b busy=%b want 0 0 0 1",
               shadow_o, err_o, done_o, busy_o);
    end
    span = 0;
    while (!done_o && span < BUDGET) begin
      start_i = ($urandom_range(0, 2) == 0);
      tick();
      span++;
    end
    start_i = 1'b0;
    tests++;
    if (span !== 2*N - 1) begin
      fails++;
      $display("FAIL restart_latency: got %0d want %0d", span, 2*N - 1);
    end
    tests++;
    if (shadow_o !== exp_sh || err_o !== 1'b0) begin
      fails++;
      $display("FAIL restart_result: shadow=%h err=%b want %h 0", shadow_o, err_o, exp_sh);
    end
    tests++;
    if (adr_q.size() != N || adr_q[N-1] !== BASE + 32'(4*(N-1))) begin
      fails++;
      $display("FAIL restart_adr: xfers=%0d want %0d ending at %h", adr_q.size(), N, BASE + 32'(4*(N-1)));
    end
  endtask

  task automatic test_reset_mid();
    int span;
    int n;
    bit ok;
    logic [N*8-1:0] exp_sh;
    randomize_fuse();
    wait_states = 2;
    exp_sh = ref_shadow(1'b0, 0);
    pulse_start();
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == BASE + 32'd4) && n < BUDGET) begin
      tick();
      n++;
    end
    tests++;
    if (n >= BUDGET) begin
      fails++;
      $display("FAIL mid_reach: byte 1 request not seen within %0d cycles", BUDGET);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy_o !== 1'b0 || shadow_o !== '0) begin
      fails++;
      $display("FAIL mid_reset: cyc=%b stb=%b busy=%b shadow=%h want 0 0 0 0",
               wbm_cyc_o, wbm_stb_o, busy_o, shadow_o);
    end
    clear_mon();
    rst_n = 1'b1;
    wait_load(span, ok);
    tests++;
    if (!ok || span !== N*(2 + 2) - 1 || shadow_o !== exp_sh) begin
      fails++;
      $display("FAIL mid_reload: done=%b span=%0d shadow=%h want 1 %0d %h", ok, span, shadow_o, N*4 - 1, exp_sh);
    end
    tests++;
    if (adr_q.size() == 0 || adr_q[0] !== BASE) begin
      fails++;
      $display("FAIL mid_first_adr: xfers=%0d want first address %h", adr_q.size(), BASE);
    end
    wait_states = 0;
  endtask

`ifdef EFUSE_LOADER_CRC_EN
  task automatic test_crc();
    int span;
    bit ok;
    fuse[0] = 8'h01; fuse[1] = 8'h02; fuse[2] = 8'h03; fuse[3] = 8'h48;
    pulse_start();
    tests++;
    if (crc_ok_o !== 1'b0) begin
      fails++;
      $display("FAIL crc_busy: got %b want 0", crc_ok_o);
    end
    wait_load(span, ok);
    tests++;
    if (!ok || crc_ok_o !== 1'b1) begin
      fails++;
      $display("FAIL crc_good: done=%b crc_ok=%b want 1 1", ok, crc_ok_o);
    end
    fuse[3] = 8'h49;
    pulse_start();
    wait_load(span, ok);
    tests++;
    if (!ok || crc_ok_o !== 1'b0) begin
      fails++;
      $display("FAIL crc_bad: done=%b crc_ok=%b want 1 0", ok, crc_ok_o);
    end
  endtask
`endif

  task automatic test_random();
    int             span, w, sb, exp_span;
    bit             ok, st;
    logic [N*8-1:0] exp_sh;
    for (int it = 0; it < 12; it++) begin
      randomize_fuse();
      w  = $urandom_range(0, 3);
      st = ($urandom_range(0, 2) == 0);
      sb = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) fuse[N-1] = ref_crc(N - 1);
      wait_states = w; stall_en = st; stall_byte = sb;
      spur_en = 1'($urandom_range(0, 1));
      exp_sh   = ref_shadow(st, sb);
      exp_span = st ? sb*(w + 2) + TO : N*(w + 2) - 1;
      pulse_start();
      wait_load(span, ok);
      tests++;
      if (!ok || span !== exp_span) begin
        fails++;
        $display("FAIL rnd%0d_latency: done=%b span=%0d want 1 %0d (w=%0d stall=%b@%0d)",
                 it, ok, span, exp_span, w, st, sb);
      end
      tests++;
      if (shadow_o !== exp_sh || err_o !== st) begin
        fails++;
        $display("FAIL rnd%0d_result: shadow=%h err=%b want %h %b", it, shadow_o, err_o, exp_sh, st);
      end
      tests++;
      if (adr_q.size() != (st ? sb : N)) begin
        fails++;
        $display("FAIL rnd%0d_xfers: got %0d want %0d", it, adr_q.size(), st ? sb : N);
      end
`ifdef EFUSE_LOADER_CRC_EN
      tests++;
      if (crc_ok_o !== (!st && ref_crc(N - 1) == fuse[N-1])) begin
        fails++;
        $display("FAIL rnd%0d_crc_ok: got %b want %b", it, crc_ok_o, !st && ref_crc(N - 1) == fuse[N-1]);
      end
`endif
    end
    wait_states = 0; stall_en = 1'b0; spur_en = 1'b0;
  endtask

  task automatic test_bus_rules();
    tests++;
    if (bus_viol !== 0) begin
      fails++;
      $display("FAIL bus_static: %0d cycles with we!=0, sel!=0001 or cyc!=stb, want 0", bus_viol);
    end
    tests++;
    if (glitch !== 0) begin
      fails++;
      $display("FAIL bus_steady: %0d address changes inside a strobe, want 0", glitch);
    end
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_wait_states();
    test_timeout();
    test_restart();
    test_reset_mid();
`ifdef EFUSE_LOADER_CRC_EN
    test_crc();
`endif
    test_random();
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
